// File: rtl/match_sequencer.sv
// Match phase controller: sequences idle, kickoff countdown, play, goal pause and game over,
// and owns the match clock, both scores and the movement gate for the field controllers.
module match_sequencer #(
  parameter int TICKS_PER_SECOND   = 50000000,
  parameter int MATCH_SECONDS      = 180,
  parameter int KICKOFF_SECONDS    = 3,
  parameter int GOAL_PAUSE_SECONDS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_request,
  input  logic       blue_goal,
  input  logic       red_goal,
  output logic [2:0] phase,
  output logic       play_enable,
  output logic       reposition,
  output logic [3:0] countdown,
  output logic [7:0] time_left,
  output logic [6:0] blue_score,
  output logic [6:0] red_score,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    KICKOFF    = 3'd1,
    PLAY       = 3'd2,
    GOAL_PAUSE = 3'd3,
    GAME_OVER  = 3'd4
  } phase_t;

  localparam int            PW         = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SECOND - 1);
  localparam logic [7:0]    MATCH_INIT = 8'(MATCH_SECONDS);
  localparam logic [3:0]    KICK_INIT  = 4'(KICKOFF_SECONDS);
  localparam logic [3:0]    PAUSE_INIT = 4'(GOAL_PAUSE_SECONDS);
  localparam logic [6:0]    SCORE_MAX  = 7'd127;

  // The state register drives the phase output directly, so phase doubles as the FSM debug view.
  phase_t        state;
  logic [PW-1:0] presc;
  logic          start_q;
  logic          start_pulse;
  logic          counting;
  logic          sec_tick;
  logic [6:0]    blue_next;
  logic [6:0]    red_next;
  logic [1:0]    winner_next;

  assign phase = state;

  always_comb begin
    start_pulse = start_request & ~start_q;
    counting    = (state == KICKOFF) || (state == PLAY) || (state == GOAL_PAUSE);
    sec_tick    = counting && (presc == PRESC_LAST);
    blue_next   = (blue_goal && (blue_score != SCORE_MAX)) ? blue_score + 7'd1 : blue_score;
    red_next    = (red_goal  && (red_score  != SCORE_MAX)) ? red_score  + 7'd1 : red_score;
    if (blue_next > red_next)      winner_next = 2'b01;
    else if (red_next > blue_next) winner_next = 2'b10;
    else                           winner_next = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= '0;
      start_q     <= 1'b1;
      play_enable <= 1'b0;
      reposition  <= 1'b0;
      countdown   <= 4'd0;
      time_left   <= MATCH_INIT;
      blue_score  <= 7'd0;
      red_score   <= 7'd0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
    end else begin
      start_q    <= start_request;
      reposition <= 1'b0;
      // Every transition out of a counting phase happens either on a tick (presc wraps to 0)
      // or on a goal, which clears presc explicitly below.
      if (counting) presc <= sec_tick ? '0 : presc + 1'b1;

      case (state)
        IDLE: begin
          time_left  <= MATCH_INIT;
          blue_score <= 7'd0;
          red_score  <= 7'd0;
          if (start_pulse) begin
            state      <= KICKOFF;
            presc      <= '0;
            countdown  <= KICK_INIT;
            reposition <= 1'b1;
          end
        end

        KICKOFF: begin
          if (sec_tick) begin
            if (countdown == 4'd1) begin
              state       <= PLAY;
              countdown   <= 4'd0;
              play_enable <= 1'b1;
            end else begin
              countdown <= countdown - 4'd1;
            end
          end
        end

        PLAY: begin
          blue_score <= blue_next;
          red_score  <= red_next;
          // Expiry wins over a goal pause; the goal is still credited via *_next.
          if (sec_tick && (time_left == 8'd1)) begin
            time_left   <= 8'd0;
            state       <= GAME_OVER;
            play_enable <= 1'b0;
            game_over   <= 1'b1;
            winner      <= winner_next;
          end else begin
            if (sec_tick) time_left <= time_left - 8'd1;
            if (blue_goal || red_goal) begin
              state       <= GOAL_PAUSE;
              play_enable <= 1'b0;
              countdown   <= PAUSE_INIT;
              presc       <= '0;
            end
          end
        end

        GOAL_PAUSE: begin
          if (sec_tick) begin
            if (countdown == 4'd1) begin
              state      <= KICKOFF;
              countdown  <= KICK_INIT;
              reposition <= 1'b1;
            end else begin
              countdown <= countdown - 4'd1;
            end
          end
        end

        GAME_OVER: begin
          if (start_pulse) begin
            state     <= IDLE;
            game_over <= 1'b0;
            winner    <= 2'b00;
          end
        end

        default: begin
          state       <= IDLE;
          presc       <= '0;
          play_enable <= 1'b0;
          countdown   <= 4'd0;
          game_over   <= 1'b0;
          winner      <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Randomized and directed bench for match_sequencer against a phase/elapsed-cycle reference model.
module tb_match_sequencer;

  localparam int TPS = 4;
  localparam int MS  = 5;
  localparam int KS  = 2;
  localparam int GS  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_request = 1'b0;
  logic       blue_goal = 1'b0;
  logic       red_goal = 1'b0;
  logic [2:0] phase;
  logic       play_enable;
  logic       reposition;
  logic [3:0] countdown;
  logic [7:0] time_left;
  logic [6:0] blue_score;
  logic [6:0] red_score;
  logic       game_over;
  logic [1:0] winner;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase number, cycles spent in the current phase, and match quantities.
  int m_phase;
  int m_cyc;
  int m_time;
  int m_blue;
  int m_red;
  int m_win;
  int m_repos;
  int m_prev_start;

  match_sequencer #(
    .TICKS_PER_SECOND  (TPS),
    .MATCH_SECONDS     (MS),
    .KICKOFF_SECONDS   (KS),
    .GOAL_PAUSE_SECONDS(GS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_request(start_request),
    .blue_goal    (blue_goal),
    .red_goal     (red_goal),
    .phase        (phase),
    .play_enable  (play_enable),
    .reposition   (reposition),
    .countdown    (countdown),
    .time_left    (time_left),
    .blue_score   (blue_score),
    .red_score    (red_score),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int win_of(input int b, input int r);
    if (b > r) return 1;
    if (r > b) return 2;
    return 3;
  endfunction

  task automatic enter(input int p);
    m_phase = p;
    m_cyc   = 0;
    if (p == 1) m_repos = 1;
    if (p == 4) m_win = win_of(m_blue, m_red);
    if (p == 0) m_win = 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic b, input logic g);
    bit sp;
    bit tick;
    int old_phase;
    if (r) begin
      m_phase = 0; m_cyc = 0; m_time = MS; m_blue = 0; m_red = 0;
      m_win = 0; m_repos = 0; m_prev_start = 1;
      return;
    end
    sp = s && (m_prev_start == 0);
    m_prev_start = s;
    m_repos = 0;
    tick = (m_phase >= 1 && m_phase <= 3) && ((m_cyc % TPS) == TPS - 1);
    old_phase = m_phase;
    case (m_phase)
      0: begin
        m_time = MS; m_blue = 0; m_red = 0;
        if (sp) enter(1);
      end
      1: if (tick && (m_cyc / TPS == KS - 1)) enter(2);
      2: begin
        if (b && m_blue < 127) m_blue++;
        if (g && m_red < 127) m_red++;
        if (tick) m_time--;
        if (tick && m_time == 0) enter(4);
        else if (b || g) enter(3);
      end
      3: if (tick && (m_cyc / TPS == GS - 1)) enter(1);
      default: if (sp) enter(0);
    endcase
    if (m_phase == old_phase) m_cyc++;
  endtask

  function automatic int exp_countdown();
    if (m_phase == 1) return KS - m_cyc / TPS;
    if (m_phase == 3) return GS - m_cyc / TPS;
    return 0;
  endfunction

  task automatic check_outputs();
    check("phase",       32'(phase),       32'(m_phase));
    check("play_enable", 32'(play_enable), 32'(m_phase == 2));
    check("reposition",  32'(reposition),  32'(m_repos));
    check("countdown",   32'(countdown),   32'(exp_countdown()));
    check("time_left",   32'(time_left),   32'(m_time));
    check("blue_score",  32'(blue_score),  32'(m_blue));
    check("red_score",   32'(red_score),   32'(m_red));
    check("game_over",   32'(game_over),   32'(m_phase == 4));
    check("winner",      32'(winner),      32'(m_win));
  endtask

  task automatic cycle(input logic r, input logic s, input logic b, input logic g);
    rst = r; start_request = s; blue_goal = b; red_goal = g;
    model_step(r, s, b, g);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (m_phase != p && n < budget) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("wait_phase_timeout", 32'(m_phase), 32'(p));
  endtask

  task automatic start_match();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic s, b, g, r;
    int n;

    // Reset with start held high; holding it afterwards must not start a match.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("no_kickoff_while_held", 32'(phase), 32'd0);

    // Kickoff, play and time expiry with no goals: draw.
    start_match();
    check("kickoff_entry", 32'(phase), 32'd1);
    check("kickoff_repos", 32'(reposition), 32'd1);
    wait_phase(4, 100);
    check("draw_winner", 32'(winner), 32'd3);

    // Restart from game over, then a blue goal with a red goal during the pause.
    start_match();
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    start_match();
    wait_phase(2, 50);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("goal_pause", 32'(phase), 32'd3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    wait_phase(1, 20);
    check("pause_red_ignored", 32'(red_score), 32'd0);

    // Simultaneous goals, then a red goal on the final tick.
    wait_phase(2, 50);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("both_scored", 32'({blue_score, red_score}), 32'({7'd2, 7'd1}));
    wait_phase(2, 50);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    wait_phase(2, 50);
    n = 0;
    while (!(m_phase == 2 && m_time == 1 && (m_cyc % TPS) == TPS - 1) && n < 100) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("final_tick_over", 32'(phase), 32'd4);
    check("final_tick_red", 32'(red_score), 32'd3);
    check("final_tick_winner", 32'(winner), 32'd2);

    // Blue saturation: goal at the first cycle of every play phase.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    start_match();
    for (int i = 0; i < 130; i++) begin
      wait_phase(2, 50);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("blue_saturated", 32'(blue_score), 32'd127);
    wait_phase(4, 100);
    check("blue_wins", 32'(winner), 32'd1);
    start_match();
    check("back_to_idle", 32'(phase), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_clears", 32'({time_left, blue_score, red_score}), 32'({8'd5, 7'd0, 7'd0}));

    // Reset mid-play with start held high.
    start_match();
    wait_phase(2, 50);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_mid_play", 32'(phase), 32'd0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("held_after_reset", 32'(phase), 32'd0);

    // Randomized play.
    s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) s = ~s;
      b = ($urandom_range(0, 9) == 0);
      g = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 599) == 0);
      cycle(r, s, b, g);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
